nios_multi_timer: RTL and testbench

Parametrised multi-channel Avalon-MM interval timer for the Nios II system, and the successor of the single-channel system clock timer. It provides NUM_CH independent down-counters, each with its own period, a per-channel clock prescaler, one-shot or continuous mode, a snapshot register and a per-channel interrupt. It sits on the Nios data master as a 32-bit slave with one-cycle registered read latency.

---
 rtl/nios_multi_timer.sv | 174 +++++++++++++++++
 tb/tb_nios_multi_timer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_multi_timer.sv
// nios_multi_timer: NUM_CH independent prescaled down-counters on a 32-bit
// Avalon-MM slave. Each channel has STATUS/CONTROL/PERIOD/SNAP registers and
// its own interrupt; reads are registered with one cycle of latency.
module nios_multi_timer #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'h02FAF07F,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         AW           = 2 + CH_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    logic              wr_en;
    logic [1:0]        reg_sel;
    logic [CH_W-1:0]   ch_idx;
    logic [31:0]       rd_ch [NUM_CH];
    logic [NUM_CH-1:0] irq_next;
    logic [31:0]       readdata_reg;
    logic [31:0]       readdata_next;
    logic              irq_any_reg;

    assign wr_en   = chipselect && !write_n;
    assign reg_sel = address[1:0];
    assign ch_idx  = address[AW-1:2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0]   period_reg, period_next;
            logic [CNT_W-1:0]   count_reg, count_next;
            logic [CNT_W-1:0]   snap_reg, snap_next;
            logic [PRESC_W-1:0] presc_reg, presc_next;
            logic [PRESC_W-1:0] presc_cnt_reg, presc_cnt_next;
            logic               ito_reg, ito_next;
            logic               cont_reg, cont_next;
            logic               to_reg, to_next;
            logic               run_reg, run_next;
            logic               irq_reg;
            logic               ch_wr, start, stop, tick, expire;

            assign ch_wr  = wr_en && (ch_idx == CH_W'(gi));
            assign start  = ch_wr && (reg_sel == REG_CONTROL) && writedata[2];
            assign stop   = ch_wr && (reg_sel == REG_CONTROL) && writedata[3];
            assign tick   = run_reg && (presc_cnt_reg == presc_reg);
            assign expire = tick && (count_reg == '0);

            // Next-state: later assignments override earlier ones, which
            // encodes the priorities (START over STOP, expiry set over W1C,
            // PERIOD write over everything touching RUN/counter).
            always_comb begin
                period_next    = period_reg;
                count_next     = count_reg;
                snap_next      = snap_reg;
                presc_next     = presc_reg;
                presc_cnt_next = presc_cnt_reg;
                ito_next       = ito_reg;
                cont_next      = cont_reg;
                to_next        = to_reg;
                run_next       = run_reg;

                if (run_reg)
                    presc_cnt_next = (presc_cnt_reg == presc_reg) ? '0
                                   : presc_cnt_reg + PRESC_W'(1);
                if (tick)
                    count_next = (count_reg != '0) ? count_reg - CNT_W'(1) : period_reg;
                if (expire && !cont_reg)
                    run_next = 1'b0;

                if (ch_wr && (reg_sel == REG_STATUS) && writedata[0])
                    to_next = 1'b0;
                if (expire)
                    to_next = 1'b1;

                if (ch_wr && (reg_sel == REG_CONTROL)) begin
                    ito_next   = writedata[0];
                    cont_next  = writedata[1];
                    presc_next = writedata[8 +: PRESC_W];
                end
                if (stop) begin
                    run_next       = 1'b0;
                    presc_cnt_next = '0;
                end
                if (start) begin
                    run_next       = 1'b1;
                    presc_cnt_next = '0;
                end

                // Snapshot takes the counter as it was before this edge's tick.
                if (ch_wr && (reg_sel == REG_SNAP))
                    snap_next = count_reg;

                if (ch_wr && (reg_sel == REG_PERIOD)) begin
                    period_next    = writedata[CNT_W-1:0];
                    count_next     = writedata[CNT_W-1:0];
                    presc_cnt_next = '0;
                    run_next       = 1'b0;
                end
            end

            // Channel state registers; irq is built from next-state so it is a
            // clean flop output that moves on the same edge as TO/ITO.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    period_reg    <= RESET_PERIOD[CNT_W-1:0];
                    count_reg     <= RESET_PERIOD[CNT_W-1:0];
                    snap_reg      <= '0;
                    presc_reg     <= '0;
                    presc_cnt_reg <= '0;
                    ito_reg       <= 1'b0;
                    cont_reg      <= 1'b0;
                    to_reg        <= 1'b0;
                    run_reg       <= 1'b0;
                    irq_reg       <= 1'b0;
                end else begin
                    period_reg    <= period_next;
                    count_reg     <= count_next;
                    snap_reg      <= snap_next;
                    presc_reg     <= presc_next;
                    presc_cnt_reg <= presc_cnt_next;
                    ito_reg       <= ito_next;
                    cont_reg      <= cont_next;
                    to_reg        <= to_next;
                    run_reg       <= run_next;
                    irq_reg       <= irq_next[gi];
                end
            end

            assign irq_next[gi] = to_next && ito_next;
            assign irq[gi]      = irq_reg;

            assign rd_ch[gi] = (reg_sel == REG_STATUS)  ? {30'd0, run_reg, to_reg} :
                               (reg_sel == REG_CONTROL) ? 32'({presc_reg, 6'd0, cont_reg, ito_reg}) :
                               (reg_sel == REG_PERIOD)  ? 32'(period_reg) :
                                                          32'(snap_reg);
        end
    endgenerate

    // Read mux: unpopulated channel slots read as zero.
    always_comb begin
        readdata_next = '0;
        if (int'(ch_idx) < NUM_CH)
            readdata_next = rd_ch[ch_idx];
    end

    // Registered read data and combined interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
            irq_any_reg  <= 1'b0;
        end else begin
            readdata_reg <= readdata_next;
            irq_any_reg  <= |irq_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq_any  = irq_any_reg;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Bench for nios_multi_timer: a 4-channel instance for most scenarios and a
// 3-channel instance for the unpopulated-channel checks. Reads go through an
// expectation queue popped when readdata becomes valid.
module tb_nios_multi_timer;

    localparam logic [31:0] RST_PER = 32'h02FAF07F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        sel3;
    logic [31:0] readdata, readdata3;
    logic [3:0]  irq;
    logic [2:0]  irq3;
    logic        irq_any, irq_any3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] val;
        logic        t3;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          ch;
        int          rg;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[16];

    nios_multi_timer #(.NUM_CH(4)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect && !sel3),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    nios_multi_timer #(.NUM_CH(3)) u_dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect && sel3),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata3),
        .irq        (irq3),
        .irq_any    (irq_any3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end else begin
            $display("check %s: got 0x%08h expected 0x%08h ok", nm, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic t3, input int ch, input int rg, input logic [31:0] d);
        sel3       = t3;
        address    = 4'(ch * 4 + rg);
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        sel3       = 1'b0;
    endtask

    task automatic rd(input logic t3, input int ch, input int rg, input logic [31:0] e, input string nm);
        exp_t item;
        address    = 4'(ch * 4 + rg);
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back('{val: e, t3: t3, name: nm});
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        item = exp_q.pop_front();
        check(item.name, item.t3 ? readdata3 : readdata, item.val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int c3;
        logic [31:0] e3;

        for (int ch = 0; ch < 4; ch++)
            for (int rg = 0; rg < 4; rg++)
                tbl[ch * 4 + rg] = '{ch: ch, rg: rg, exp: (rg == 2) ? RST_PER : 32'd0};

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0; sel3 = 1'b0;
        #23;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_irq_any", 32'(irq_any), 32'd0);
        reset_n = 1'b1;
        wait_n(1);

        for (int i = 0; i < 16; i++)
            rd(1'b0, tbl[i].ch, tbl[i].rg, tbl[i].exp,
               $sformatf("rst_ch%0d_reg%0d", tbl[i].ch, tbl[i].rg));
        check("rst_irq_after_reads", 32'(irq), 32'd0);

        // ch1 continuous, PERIOD 9, PRESC 0: irq rises 10 edges after START.
        wr(1'b0, 1, 2, 32'd9);
        wr(1'b0, 1, 1, 32'h7);
        for (int k = 1; k <= 10; k++) begin
            wait_n(1);
            check($sformatf("ch1_irq_k%0d", k), 32'(irq[1]), (k >= 10) ? 32'd1 : 32'd0);
        end
        check("ch1_irq_any", 32'(irq_any), 32'd1);
        wr(1'b0, 1, 0, 32'd1);
        check("ch1_irq_cleared", 32'(irq[1]), 32'd0);
        wait_n(8);
        check("ch1_irq_k19", 32'(irq[1]), 32'd0);
        wait_n(1);
        check("ch1_irq_k20", 32'(irq[1]), 32'd1);
        wr(1'b0, 1, 0, 32'd1);
        check("ch1_irq_cleared2", 32'(irq[1]), 32'd0);
        wait_n(8);
        wr(1'b0, 1, 0, 32'd1);
        check("ch1_w1c_on_expiry_irq", 32'(irq[1]), 32'd1);
        rd(1'b0, 1, 0, 32'h3, "ch1_w1c_on_expiry_status");
        wr(1'b0, 1, 1, 32'h8);
        wr(1'b0, 1, 0, 32'd1);
        rd(1'b0, 1, 0, 32'h0, "ch1_stopped_status");
        check("ch1_irq_off", 32'(irq[1]), 32'd0);

        // ch2 PERIOD 0, PRESC 2, continuous: TO every 3 cycles.
        wr(1'b0, 2, 2, 32'd0);
        wr(1'b0, 2, 1, 32'h207);
        wait_n(2);
        check("ch2_p0_k2", 32'(irq[2]), 32'd0);
        wait_n(1);
        check("ch2_p0_k3", 32'(irq[2]), 32'd1);
        wr(1'b0, 2, 0, 32'd1);
        check("ch2_p0_k4", 32'(irq[2]), 32'd0);
        wait_n(1);
        check("ch2_p0_k5", 32'(irq[2]), 32'd0);
        wait_n(1);
        check("ch2_p0_k6", 32'(irq[2]), 32'd1);
        wr(1'b0, 2, 1, 32'h8);
        wr(1'b0, 2, 0, 32'd1);

        // ch2 one-shot PERIOD 3, PRESC 4: TO after exactly 20 cycles.
        wr(1'b0, 2, 2, 32'd3);
        wr(1'b0, 2, 1, 32'h404);
        wait_n(19);
        rd(1'b0, 2, 0, 32'h2, "ch2_oneshot_k20_pre");
        rd(1'b0, 2, 0, 32'h1, "ch2_oneshot_k21");
        rd(1'b0, 2, 1, 32'h400, "ch2_control_readback");
        wr(1'b0, 2, 3, 32'd0);
        rd(1'b0, 2, 3, 32'd3, "ch2_oneshot_count_held");
        wr(1'b0, 2, 0, 32'd1);
        wait_n(100);
        rd(1'b0, 2, 0, 32'h0, "ch2_no_further_to");
        wr(1'b0, 2, 3, 32'd0);
        rd(1'b0, 2, 3, 32'd3, "ch2_count_still_held");

        // START and STOP together: START wins.
        wr(1'b0, 2, 1, 32'hC);
        rd(1'b0, 2, 0, 32'h2, "ch2_start_stop_run");
        wr(1'b0, 2, 2, 32'd3);
        rd(1'b0, 2, 0, 32'h0, "ch2_period_write_stops");

        // ch3 free-runs in the background; ch0 snapshot and PERIOD write.
        wr(1'b0, 3, 2, 32'd1000);
        wr(1'b0, 3, 1, 32'h6);
        c3 = cyc;
        wr(1'b0, 0, 2, 32'd100);
        wr(1'b0, 0, 1, 32'h6);
        wait_n(43);
        wr(1'b0, 0, 3, 32'd0);
        rd(1'b0, 0, 3, 32'd57, "ch0_snap_57");
        wr(1'b0, 0, 2, 32'd200);
        rd(1'b0, 0, 0, 32'h0, "ch0_period_write_run0");
        wr(1'b0, 0, 3, 32'd0);
        rd(1'b0, 0, 3, 32'd200, "ch0_counter_200");
        wr(1'b0, 3, 3, 32'd0);
        e3 = 32'(1000 - (cyc - 1 - c3));
        rd(1'b0, 3, 3, e3, "ch3_unaffected_count");
        rd(1'b0, 3, 0, 32'h2, "ch3_still_running");
        wr(1'b0, 3, 1, 32'h8);

        // 3-channel build: channel 3 slot is unpopulated.
        wr(1'b1, 3, 2, 32'h55);
        wr(1'b1, 3, 1, 32'h7);
        rd(1'b1, 3, 2, 32'h0, "n3_ch3_period");
        rd(1'b1, 3, 1, 32'h0, "n3_ch3_control");
        rd(1'b1, 3, 0, 32'h0, "n3_ch3_status");
        rd(1'b1, 2, 2, RST_PER, "n3_ch2_period");
        check("n3_irq", 32'(irq3), 32'd0);
        rd(1'b0, 3, 2, 32'd1000, "n4_ch3_period_untouched");

        // Asynchronous reset mid-count.
        wr(1'b0, 1, 2, 32'd9);
        wr(1'b0, 1, 1, 32'h7);
        wait_n(12);
        check("pre_reset_irq1", 32'(irq[1]), 32'd1);
        rd(1'b0, 1, 2, 32'd9, "pre_reset_period");
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_irq_any", 32'(irq_any), 32'd0);
        check("async_rst_readdata", readdata, 32'd0);
        check("async_rst_readdata3", readdata3, 32'd0);
        wait_n(1);
        reset_n = 1'b1;
        rd(1'b0, 1, 2, RST_PER, "post_rst_period");
        rd(1'b0, 1, 0, 32'h0, "post_rst_status");
        rd(1'b0, 1, 1, 32'h0, "post_rst_control");
        wait_n(20);
        check("post_rst_no_irq", 32'(irq), 32'd0);
        rd(1'b0, 1, 0, 32'h0, "post_rst_not_running");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
